// File: rtl/baseline_align_subtract_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : wavelet_bl_pkg
//  Description : Shared types for the baseline align/subtract stage.
//                - mode_e      : output mode encodings (cfg_mode)
//                - lat_state_e : latency-measurement FSM states
//                - lane_lsb    : bit offset of a lane inside a packed beat
//  Revision    : 1.0 - initial release
// ============================================================================
package wavelet_bl_pkg;

    typedef enum logic [1:0] {
        MODE_SUB    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_FREEZE = 2'd2,
        MODE_BASE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        LAT_ARMED = 2'd0,
        LAT_COUNT = 2'd1,
        LAT_DONE  = 2'd2
    } lat_state_e;

    // Lane i of a packed beat occupies bits [width*(i+1)-1 : width*i].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baseline_align_subtract_if.sv
`default_nettype none
// ============================================================================
//  Interface   : baseline_align_subtract_if
//  Description : Bundles configuration, raw/baseline input beats and all
//                result/status outputs of baseline_align_subtract.
//                master : driver side (upstream + control)
//                slave  : the alignment/subtraction block
//  Ports (slave view):
//    in  clr, cfg_mode[1:0], cfg_delay[DELAY_W:0]
//    in  din_valid, din[BEAT_W-1:0], bl_valid, bl[BEAT_W-1:0]
//    out dout_valid, dout, dout_bl, sat_flag, occupancy, lat_measured,
//        lat_done, lat_err, ovf_err, unf_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface baseline_align_subtract_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int MAX_DELAY  = 256
);
    localparam int DELAY_W = $clog2(MAX_DELAY);
    localparam int BEAT_W  = DATA_WIDTH * LANES;

    logic                 clr;
    logic [1:0]           cfg_mode;
    logic [DELAY_W:0]     cfg_delay;
    logic                 din_valid;
    logic [BEAT_W-1:0]    din;
    logic                 bl_valid;
    logic [BEAT_W-1:0]    bl;
    logic                 dout_valid;
    logic [BEAT_W-1:0]    dout;
    logic [BEAT_W-1:0]    dout_bl;
    logic                 sat_flag;
    logic [DELAY_W:0]     occupancy;
    logic [DELAY_W:0]     lat_measured;
    logic                 lat_done;
    logic                 lat_err;
    logic                 ovf_err;
    logic                 unf_err;

    modport master (
        output clr, cfg_mode, cfg_delay, din_valid, din, bl_valid, bl,
        input  dout_valid, dout, dout_bl, sat_flag, occupancy,
               lat_measured, lat_done, lat_err, ovf_err, unf_err
    );

    modport slave (
        input  clr, cfg_mode, cfg_delay, din_valid, din, bl_valid, bl,
        output dout_valid, dout, dout_bl, sat_flag, occupancy,
               lat_measured, lat_done, lat_err, ovf_err, unf_err
    );

endinterface
`default_nettype wire

// File: rtl/baseline_align_subtract_lane_sat_sub.sv
`default_nettype none
// ============================================================================
//  Module      : lane_sat_sub
//  Description : One lane of signed subtraction a - b at DATA_WIDTH+1 bits,
//                clamped back to the signed DATA_WIDTH range.
//  Ports:
//    a_i   in  DATA_WIDTH  minuend (signed)
//    b_i   in  DATA_WIDTH  subtrahend (signed)
//    y_o   out DATA_WIDTH  clamped difference
//    sat_o out 1           clamp was applied
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_sat_sub #(
    parameter int DATA_WIDTH = 16
) (
    input  wire logic [DATA_WIDTH-1:0] a_i,
    input  wire logic [DATA_WIDTH-1:0] b_i,
    output logic      [DATA_WIDTH-1:0] y_o,
    output logic                       sat_o
);

    logic [DATA_WIDTH:0] w_diff;

    assign w_diff = {a_i[DATA_WIDTH-1], a_i} - {b_i[DATA_WIDTH-1], b_i};

    // The difference fits in DATA_WIDTH bits exactly when the two top bits
    // agree; otherwise the extended sign bit tells which rail to clamp to.
    always_comb begin
        y_o   = w_diff[DATA_WIDTH-1:0];
        sat_o = 1'b0;
        if (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1]) begin
            sat_o = 1'b1;
            y_o   = w_diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/baseline_align_subtract.sv
`default_nettype none
// ============================================================================
//  Module      : baseline_align_subtract
//  Description : Buffers raw beats until the matching baseline beat arrives
//                (pairing by order of valid), then registers the per-lane
//                saturated difference. Also measures din->bl latency once
//                per arm and compares it with cfg_delay.
//  Ports:
//    clk  in  sole clock
//    rst  in  asynchronous active-high reset
//    bus  slave modport of baseline_align_subtract_if (config, din/bl
//         beats, dout/dout_bl/sat_flag, occupancy, latency and error flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module baseline_align_subtract #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int MAX_DELAY  = 256
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    baseline_align_subtract_if.slave   bus
);
    import wavelet_bl_pkg::*;

    localparam int DELAY_W = $clog2(MAX_DELAY);
    localparam int BEAT_W  = DATA_WIDTH * LANES;

    localparam logic [DELAY_W:0]   c_full    = (DELAY_W+1)'(MAX_DELAY);
    localparam logic [DELAY_W:0]   c_cnt_one = {{DELAY_W{1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] c_ptr_one = {{(DELAY_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Raw beat buffer (distributed RAM, asynchronous read)
    // ------------------------------------------------------------------
    logic [BEAT_W-1:0]  mem_q [MAX_DELAY];
    logic [DELAY_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DELAY_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DELAY_W:0]   count_q, count_d;

    logic w_empty, w_full, w_push, w_pop, w_ovf, w_unf;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_full);
    // clr wins over any push/pop in the same cycle.
    assign w_pop   = bus.bl_valid & ~w_empty & ~bus.clr;
    // At full a push is still taken when a pop frees a slot this cycle.
    assign w_push  = bus.din_valid & (~w_full | w_pop) & ~bus.clr;
    assign w_ovf   = bus.din_valid & w_full & ~bus.bl_valid;
    assign w_unf   = bus.bl_valid & w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    logic [BEAT_W-1:0] w_raw;
    assign w_raw = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
        if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
        if (w_push && !w_pop)      count_d = count_q + c_cnt_one;
        else if (!w_push && w_pop) count_d = count_q - c_cnt_one;
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane subtraction
    // ------------------------------------------------------------------
    mode_e             w_mode;
    logic [BEAT_W-1:0] held_bl_q, held_bl_d;
    logic [BEAT_W-1:0] w_sub_bl;
    logic [BEAT_W-1:0] w_diff;
    logic [LANES-1:0]  w_lane_sat;

    assign w_mode   = mode_e'(bus.cfg_mode);
    assign w_sub_bl = (w_mode == MODE_FREEZE) ? held_bl_q : bus.bl;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_sat_sub #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .a_i   (w_raw[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
            .b_i   (w_sub_bl[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
            .y_o   (w_diff[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
            .sat_o (w_lane_sat[gi])
        );
    end

    // ------------------------------------------------------------------
    // Output registers and sticky errors
    // ------------------------------------------------------------------
    logic              dout_valid_q, dout_valid_d;
    logic [BEAT_W-1:0] dout_q, dout_d;
    logic [BEAT_W-1:0] dout_bl_q, dout_bl_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    always_comb begin
        dout_valid_d = w_pop;
        dout_d       = dout_q;
        dout_bl_d    = dout_bl_q;
        sat_d        = sat_q;
        held_bl_d    = held_bl_q;
        ovf_d        = ovf_q | w_ovf;
        unf_d        = unf_q | w_unf;
        if (w_pop) begin
            dout_bl_d = w_sub_bl;
            // sat_flag only reflects beats whose data is a subtraction.
            case (w_mode)
                MODE_SUB, MODE_FREEZE: begin
                    dout_d = w_diff;
                    sat_d  = |w_lane_sat;
                end
                MODE_BYPASS: begin
                    dout_d = w_raw;
                    sat_d  = 1'b0;
                end
                default: begin
                    dout_d = bus.bl;
                    sat_d  = 1'b0;
                end
            endcase
            if (w_mode != MODE_FREEZE) held_bl_d = bus.bl;
        end
        if (bus.clr) begin
            held_bl_d = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Latency measurement FSM
    // ------------------------------------------------------------------
    lat_state_e       lat_state_q, lat_state_d;
    logic [DELAY_W:0] lat_cnt_q, lat_cnt_d;
    logic             lat_done_q, lat_done_d;
    logic             lat_err_q, lat_err_d;

    always_comb begin
        lat_state_d = lat_state_q;
        lat_cnt_d   = lat_cnt_q;
        lat_done_d  = lat_done_q;
        lat_err_d   = lat_err_q;
        case (lat_state_q)
            LAT_ARMED: begin
                if (bus.din_valid) begin
                    if (bus.bl_valid) begin
                        // Baseline in the same cycle as the first raw beat.
                        lat_cnt_d   = '0;
                        lat_done_d  = 1'b1;
                        lat_err_d   = (bus.cfg_delay != '0);
                        lat_state_d = LAT_DONE;
                    end else begin
                        // The din cycle itself counts as 1.
                        lat_cnt_d   = c_cnt_one;
                        lat_state_d = LAT_COUNT;
                    end
                end
            end
            LAT_COUNT: begin
                if (bus.bl_valid) begin
                    lat_done_d  = 1'b1;
                    lat_err_d   = (lat_cnt_q != bus.cfg_delay);
                    lat_state_d = LAT_DONE;
                end else if (lat_cnt_q != '1) begin
                    lat_cnt_d = lat_cnt_q + c_cnt_one;
                end
            end
            default: begin
                lat_state_d = LAT_DONE;
            end
        endcase
        if (bus.clr) begin
            lat_state_d = LAT_ARMED;
            lat_cnt_d   = '0;
            lat_done_d  = 1'b0;
            lat_err_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            held_bl_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_bl_q    <= '0;
            sat_q        <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            lat_state_q  <= LAT_ARMED;
            lat_cnt_q    <= '0;
            lat_done_q   <= 1'b0;
            lat_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            held_bl_q    <= held_bl_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            dout_bl_q    <= dout_bl_d;
            sat_q        <= sat_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            lat_state_q  <= lat_state_d;
            lat_cnt_q    <= lat_cnt_d;
            lat_done_q   <= lat_done_d;
            lat_err_q    <= lat_err_d;
        end
    end

    assign bus.dout_valid   = dout_valid_q;
    assign bus.dout         = dout_q;
    assign bus.dout_bl      = dout_bl_q;
    assign bus.sat_flag     = sat_q;
    assign bus.occupancy    = count_q;
    assign bus.lat_measured = lat_cnt_q;
    assign bus.lat_done     = lat_done_q;
    assign bus.lat_err      = lat_err_q;
    assign bus.ovf_err      = ovf_q;
    assign bus.unf_err      = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_baseline_align_subtract.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baseline_align_subtract
//  Description : Directed self-checking bench for baseline_align_subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baseline_align_subtract;

    localparam int DW = 16;
    localparam int L  = 16;
    localparam int MD = 256;
    localparam int BW = DW * L;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    baseline_align_subtract_if #(.DATA_WIDTH(DW), .LANES(L), .MAX_DELAY(MD)) bus ();

    baseline_align_subtract #(.DATA_WIDTH(DW), .LANES(L), .MAX_DELAY(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers and reference model ----------------
    function automatic logic [BW-1:0] rep(input logic [DW-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < L; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] din_pat(input int k);
        logic [BW-1:0] r;
        for (int i = 0; i < L; i++) r[i*DW +: DW] = 16'(k*97 + i*301 - 2000);
        return r;
    endfunction

    function automatic logic [BW-1:0] bl_pat(input int k);
        logic [BW-1:0] r;
        for (int i = 0; i < L; i++) r[i*DW +: DW] = 16'(i*13 - k*5 + 40);
        return r;
    endfunction

    // Returns {sat, per-lane clamped a-b}.
    function automatic logic [BW:0] sub_model(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic          s;
        int            d;
        s = 1'b0;
        for (int i = 0; i < L; i++) begin
            d = int'($signed(a[i*DW +: DW])) - int'($signed(b[i*DW +: DW]));
            if (d > 32767) begin d = 32767; s = 1'b1; end
            else if (d < -32768) begin d = -32768; s = 1'b1; end
            r[i*DW +: DW] = 16'(d);
        end
        return {s, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din_valid = 1'b0;
        bus.bl_valid  = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic do_clr();
        idle_inputs();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    // ---------------------------- tests -----------------------------------
    task automatic test_reset();
        logic [BW*2+4:0] got;
        idle_inputs();
        bus.cfg_mode  = 2'd0;
        bus.cfg_delay = '0;
        bus.din       = '0;
        bus.bl        = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        got = {bus.dout, bus.dout_bl, bus.dout_valid, bus.sat_flag, bus.lat_done, bus.lat_err, bus.ovf_err};
        n_checks++;
        if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
        else n_pass++;
        n_checks++;
        if (bus.occupancy !== 9'd0 || bus.lat_measured !== 9'd0 || bus.unf_err !== 1'b0)
            $display("FAIL reset_counters: occ=%0d lat=%0d unf=%b expected 0 0 0",
                     bus.occupancy, bus.lat_measured, bus.unf_err);
        else n_pass++;
    endtask

    task automatic test_latency_match();
        localparam int N = 24;
        logic [BW:0] e;
        do_clr();
        bus.cfg_mode  = 2'd0;
        bus.cfg_delay = 9'd154;
        for (int c = 0; c < 154 + N; c++) begin
            bus.din_valid = (c < N);
            bus.din       = din_pat(c);
            bus.bl_valid  = (c >= 154);
            bus.bl        = (c >= 154) ? bl_pat(c - 154) : '0;
            step();
            if (c == 100) begin
                n_checks++;
                if (bus.dout_valid !== 1'b0 || bus.occupancy !== 9'(N))
                    $display("FAIL lat_match_wait: valid=%b occ=%0d expected 0 %0d",
                             bus.dout_valid, bus.occupancy, N);
                else n_pass++;
            end
            if (c >= 154) begin
                e = sub_model(din_pat(c - 154), bl_pat(c - 154));
                n_checks++;
                if ({bus.dout_valid, bus.sat_flag, bus.dout, bus.dout_bl} !== {1'b1, e, bl_pat(c - 154)})
                    $display("FAIL lat_match_beat%0d: got v=%b s=%b %h expected v=1 s=%b %h",
                             c - 154, bus.dout_valid, bus.sat_flag, bus.dout, e[BW], e[BW-1:0]);
                else n_pass++;
            end
        end
        idle_inputs();
        n_checks++;
        if (bus.lat_measured !== 9'd154 || bus.lat_done !== 1'b1 || bus.lat_err !== 1'b0)
            $display("FAIL lat_match_result: lat=%0d done=%b err=%b expected 154 1 0",
                     bus.lat_measured, bus.lat_done, bus.lat_err);
        else n_pass++;
    endtask

    task automatic test_latency_mismatch();
        do_clr();
        bus.cfg_mode  = 2'd0;
        bus.cfg_delay = 9'd150;
        for (int c = 0; c < 158; c++) begin
            bus.din_valid = (c < 4);
            bus.din       = din_pat(c);
            bus.bl_valid  = (c >= 154);
            bus.bl        = '0;
            step();
        end
        idle_inputs();
        n_checks++;
        if (bus.lat_measured !== 9'd154 || bus.lat_done !== 1'b1 || bus.lat_err !== 1'b1)
            $display("FAIL lat_mismatch: lat=%0d done=%b err=%b expected 154 1 1",
                     bus.lat_measured, bus.lat_done, bus.lat_err);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [BW-1:0] raws [4];
        logic [BW-1:0] bls  [4];
        logic [BW-1:0] exps [4];
        logic          sats [4];
        raws[0] = rep(16'h7FFF); bls[0] = rep(16'h8000); exps[0] = rep(16'h7FFF); sats[0] = 1'b1;
        raws[1] = rep(16'h8000); bls[1] = rep(16'h0001); exps[1] = rep(16'h8000); sats[1] = 1'b1;
        raws[2] = rep(16'h0100); bls[2] = rep(16'h0040); exps[2] = rep(16'h00C0); sats[2] = 1'b0;
        raws[3] = rep(16'h0100); bls[3] = rep(16'h0040); exps[3] = rep(16'h00C0); sats[3] = 1'b1;
        raws[3][5*DW +: DW] = 16'h7FFF;
        bls[3][5*DW +: DW]  = 16'h8000;
        exps[3][5*DW +: DW] = 16'h7FFF;
        do_clr();
        bus.cfg_mode = 2'd0;
        for (int k = 0; k < 4; k++) begin
            bus.din_valid = 1'b1;
            bus.din       = raws[k];
            step();
        end
        bus.din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.bl_valid = 1'b1;
            bus.bl       = bls[k];
            step();
            n_checks++;
            if ({bus.dout_valid, bus.sat_flag, bus.dout} !== {1'b1, sats[k], exps[k]})
                $display("FAIL sat_beat%0d: got v=%b s=%b %h expected v=1 s=%b %h",
                         k, bus.dout_valid, bus.sat_flag, bus.dout, sats[k], exps[k]);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_gapped();
        logic [BW:0] e;
        int          b;
        do_clr();
        bus.cfg_mode  = 2'd0;
        bus.cfg_delay = 9'd6;
        for (int c = 0; c < 30; c++) begin
            bus.din_valid = (c % 3 == 0) && (c <= 21);
            bus.din       = din_pat(c / 3 + 50);
            bus.bl_valid  = (c % 3 == 0) && (c >= 6) && (c <= 27);
            b             = (c >= 6) ? (c - 6) / 3 + 50 : 0;
            bus.bl        = bl_pat(b);
            step();
            if (c >= 3 && c <= 23) begin
                n_checks++;
                if (bus.occupancy !== 9'd2)
                    $display("FAIL gap_occ_c%0d: got %0d expected 2", c, bus.occupancy);
                else n_pass++;
            end
            if (bus.bl_valid) begin
                e = sub_model(din_pat(b), bl_pat(b));
                n_checks++;
                if ({bus.dout_valid, bus.sat_flag, bus.dout} !== {1'b1, e})
                    $display("FAIL gap_beat%0d: got v=%b %h expected v=1 %h",
                             b, bus.dout_valid, bus.dout, e[BW-1:0]);
                else n_pass++;
            end
        end
        idle_inputs();
        n_checks++;
        if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0 || bus.lat_measured !== 9'd6 || bus.lat_err !== 1'b0)
            $display("FAIL gap_status: ovf=%b unf=%b lat=%0d err=%b expected 0 0 6 0",
                     bus.ovf_err, bus.unf_err, bus.lat_measured, bus.lat_err);
        else n_pass++;
    endtask

    task automatic test_overflow_underflow();
        do_clr();
        bus.cfg_mode = 2'd0;
        bus.bl       = '0;
        for (int k = 0; k < 257; k++) begin
            bus.din_valid = 1'b1;
            bus.din       = din_pat(k);
            step();
        end
        bus.din_valid = 1'b0;
        n_checks++;
        if (bus.ovf_err !== 1'b1 || bus.occupancy !== 9'd256 || bus.unf_err !== 1'b0)
            $display("FAIL ovf_flag: ovf=%b occ=%0d unf=%b expected 1 256 0",
                     bus.ovf_err, bus.occupancy, bus.unf_err);
        else n_pass++;
        for (int k = 0; k < 256; k++) begin
            bus.bl_valid = 1'b1;
            step();
            n_checks++;
            if ({bus.dout_valid, bus.dout} !== {1'b1, din_pat(k)})
                $display("FAIL ovf_drain%0d: got v=%b %h expected v=1 %h",
                         k, bus.dout_valid, bus.dout, din_pat(k));
            else n_pass++;
        end
        bus.bl_valid = 1'b0;
        step();
        n_checks++;
        if (bus.occupancy !== 9'd0 || bus.dout_valid !== 1'b0)
            $display("FAIL ovf_empty: occ=%0d v=%b expected 0 0", bus.occupancy, bus.dout_valid);
        else n_pass++;

        // Simultaneous push and pop at full.
        do_clr();
        for (int k = 0; k < 256; k++) begin
            bus.din_valid = 1'b1;
            bus.din       = din_pat(k);
            step();
        end
        bus.din      = din_pat(256);
        bus.bl_valid = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if ({bus.dout_valid, bus.dout} !== {1'b1, din_pat(0)} || bus.occupancy !== 9'd256 ||
            bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0)
            $display("FAIL full_pushpop: v=%b occ=%0d ovf=%b unf=%b expected 1 256 0 0",
                     bus.dout_valid, bus.occupancy, bus.ovf_err, bus.unf_err);
        else n_pass++;

        // Pop on empty.
        do_clr();
        bus.bl_valid = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (bus.dout_valid !== 1'b0 || bus.unf_err !== 1'b1)
            $display("FAIL unf_pop: v=%b unf=%b expected 0 1", bus.dout_valid, bus.unf_err);
        else n_pass++;

        // Push and pop together on empty: beat stored, no output.
        do_clr();
        bus.din_valid = 1'b1;
        bus.din       = rep(16'h1234);
        bus.bl_valid  = 1'b1;
        step();
        bus.din_valid = 1'b0;
        n_checks++;
        if (bus.dout_valid !== 1'b0 || bus.unf_err !== 1'b1 || bus.occupancy !== 9'd1)
            $display("FAIL unf_pushpop: v=%b unf=%b occ=%0d expected 0 1 1",
                     bus.dout_valid, bus.unf_err, bus.occupancy);
        else n_pass++;
        step();
        idle_inputs();
        n_checks++;
        if ({bus.dout_valid, bus.dout} !== {1'b1, rep(16'h1234)})
            $display("FAIL unf_stored: got v=%b %h expected v=1 %h",
                     bus.dout_valid, bus.dout, rep(16'h1234));
        else n_pass++;
    endtask

    task automatic test_modes();
        logic [1:0]    modes [5];
        logic [15:0]   blv   [5];
        logic [15:0]   expd  [5];
        logic [15:0]   expb  [5];
        modes[0] = 2'd0; blv[0] = 16'h0010; expd[0] = 16'h00F0; expb[0] = 16'h0010;
        modes[1] = 2'd2; blv[1] = 16'h0050; expd[1] = 16'h01F0; expb[1] = 16'h0010;
        modes[2] = 2'd1; blv[2] = 16'h0030; expd[2] = 16'h0300; expb[2] = 16'h0030;
        modes[3] = 2'd3; blv[3] = 16'h0070; expd[3] = 16'h0070; expb[3] = 16'h0070;
        modes[4] = 2'd2; blv[4] = 16'h0099; expd[4] = 16'h0490; expb[4] = 16'h0070;
        do_clr();
        for (int k = 0; k < 5; k++) begin
            bus.din_valid = 1'b1;
            bus.din       = rep(16'((k + 1) * 16'h0100));
            step();
        end
        bus.din_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.cfg_mode = modes[k];
            bus.bl_valid = 1'b1;
            bus.bl       = rep(blv[k]);
            step();
            n_checks++;
            if ({bus.dout_valid, bus.dout, bus.dout_bl} !== {1'b1, rep(expd[k]), rep(expb[k])})
                $display("FAIL mode_step%0d: got v=%b d=%h b=%h expected v=1 d=%h b=%h",
                         k, bus.dout_valid, bus.dout[15:0], bus.dout_bl[15:0], expd[k], expb[k]);
            else n_pass++;
        end
        idle_inputs();
        bus.cfg_mode = 2'd0;
    endtask

    task automatic test_reset_midstream();
        do_clr();
        bus.cfg_mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            bus.din_valid = 1'b1;
            bus.din       = rep(16'h0ABC);
            step();
        end
        bus.bl_valid = 1'b1;
        bus.bl       = rep(16'h0001);
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.dout_valid, bus.dout, bus.dout_bl, bus.sat_flag, bus.lat_done} !== '0 ||
            bus.occupancy !== 9'd0 || bus.lat_measured !== 9'd0)
            $display("FAIL rst_mid: v=%b d=%h occ=%0d lat=%0d expected all 0",
                     bus.dout_valid, bus.dout[15:0], bus.occupancy, bus.lat_measured);
        else n_pass++;
        step();
        rst = 1'b0;
        bus.bl_valid = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (bus.dout_valid !== 1'b0 || bus.unf_err !== 1'b1)
            $display("FAIL rst_after: v=%b unf=%b expected 0 1", bus.dout_valid, bus.unf_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency_match();
        test_latency_mismatch();
        test_saturation();
        test_gapped();
        test_overflow_underflow();
        test_modes();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
